// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int unsigned DIGIT_W       = 4;
    localparam int unsigned BIN_W_DEFAULT = 16;
    localparam int unsigned CNT_W         = $clog2(BIN_W_DEFAULT + 1);

    localparam logic [DIGIT_W-1:0] BCD_NINE = 4'h9;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit corrector: digits of 5 or more get +3 before the next shift.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] adj_c_o
);

    // The add wraps within the digit; a digit never exceeds 9, so no carry out is needed.
    assign adj_c_o = (digit_i >= DIGIT_W'(5)) ? (digit_i + DIGIT_W'(3)) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with saturation to all nines.
// bcd_o holds the last result so the digit selector always sees a stable value.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W      = bin2bcd_pkg::BIN_W_DEFAULT,
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned INT_DIGITS = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [BIN_W-1:0]          bin_i,
    input  logic                      start_i,
    output logic [DIGIT_W*DIGITS-1:0] bcd_o,
    output logic                      ovf_o,
    output logic                      busy_o,
    output logic                      valid_o
);

    localparam int unsigned CTR_W = $clog2(BIN_W + 1);
    localparam int unsigned SCR_W = INT_DIGITS * DIGIT_W;
    localparam int unsigned OUT_W = DIGITS * DIGIT_W;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic [SCR_W-1:0]   scr_adj;
    logic [CTR_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               hi_nz;

    // Per-digit +3 correction applied to the scratch register before each shift.
    for (genvar g = 0; g < INT_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scr_q[g*DIGIT_W +: DIGIT_W]),
            .adj_c_o (scr_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Any nonzero digit above the displayed ones means the value exceeds 10^DIGITS-1.
    if (INT_DIGITS > DIGITS) begin : g_hi
        assign hi_nz = |scr_q[SCR_W-1:OUT_W];
    end else begin : g_no_hi
        assign hi_nz = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shift_d = bin_i;
                    scr_d   = '0;
                    cnt_d   = CTR_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy_d             = 1'b1;
                {scr_d, shift_d}   = {scr_adj, shift_q} << 1;
                cnt_d              = cnt_q - CTR_W'(1);
                if (cnt_q == CTR_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (hi_nz) begin
                    bcd_d = {DIGITS{BCD_NINE}};
                    ovf_d = 1'b1;
                end else begin
                    bcd_d = scr_q[OUT_W-1:0];
                    ovf_d = 1'b0;
                end
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bcd_o   = bcd_q;
    assign ovf_o   = ovf_q;
    assign busy_o  = busy_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table plus scoreboard of expected results.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bin = '0;
    logic        start = 1'b0;
    logic [15:0] bcd;
    logic        ovf;
    logic        busy;
    logic        valid;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int n_valid = 0;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[12];

    bin2bcd_seq dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bin_i   (bin),
        .start_i (start),
        .bcd_o   (bcd),
        .ovf_o   (ovf),
        .busy_o  (busy),
        .valid_o (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] eb, input logic eo,
                            input bit push, output int n);
        exp_t e;
        bin   = b;
        start = 1'b1;
        n     = cyc + 1;
        if (push) begin
            e.bcd = eb;
            e.ovf = eo;
            e.cyc = n + 17;
            exp_q.push_back(e);
        end
        step();
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        if (exp_q.size() != 0) chk("result_timeout", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        int   n;
        int   v0;
        exp_t e;

        vecs[0]  = '{16'd1234,  16'h1234, 1'b0};
        vecs[1]  = '{16'd9999,  16'h9999, 1'b0};
        vecs[2]  = '{16'd0,     16'h0000, 1'b0};
        vecs[3]  = '{16'd10000, 16'h9999, 1'b1};
        vecs[4]  = '{16'd65535, 16'h9999, 1'b1};
        vecs[5]  = '{16'd42,    16'h0042, 1'b0};
        vecs[6]  = '{16'd1,     16'h0001, 1'b0};
        vecs[7]  = '{16'd99,    16'h0099, 1'b0};
        vecs[8]  = '{16'd100,   16'h0100, 1'b0};
        vecs[9]  = '{16'd5678,  16'h5678, 1'b0};
        vecs[10] = '{16'd9990,  16'h9990, 1'b0};
        vecs[11] = '{16'd10001, 16'h9999, 1'b1};

        fork
            // Scoreboard monitor: every valid pulse must match the oldest expectation.
            forever begin
                @(negedge clk);
                if (valid === 1'b1) begin
                    n_valid++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 32'(valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("bcd", 32'(bcd), 32'(e.bcd));
                        chk("ovf", 32'(ovf), 32'(e.ovf));
                        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        join_none

        repeat (3) step();
        rst = 1'b0;
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);

        // First conversion: busy profile across the whole latency window.
        do_start(16'd1234, 16'h1234, 1'b0, 1'b1, n);
        chk("busy_at_start", 32'(busy), 0);
        for (int k = 1; k <= 17; k++) begin
            step();
            chk("busy_window", 32'(busy), (k <= 16) ? 32'd1 : 32'd0);
        end
        drain(30);

        for (int i = 0; i < 12; i++) begin
            do_start(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, 1'b1, n);
            drain(30);
        end

        // Starts during SHIFT and DONE are ignored; the following IDLE start is taken.
        do_start(16'd1234, 16'h1234, 1'b0, 1'b1, n);
        repeat (4) step();
        bin   = 16'd5678;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (11) step();
        e.bcd = 16'h5678;
        e.ovf = 1'b0;
        e.cyc = n + 35;
        exp_q.push_back(e);
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        drain(40);

        // Reset in mid-conversion aborts it without a valid pulse.
        do_start(16'd1234, 16'h1234, 1'b0, 1'b1, n);
        drain(30);
        do_start(16'd8765, 16'h8765, 1'b0, 1'b0, n);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_bcd", 32'(bcd), 0);
        chk("abort_ovf", 32'(ovf), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(valid), 0);
        v0 = n_valid;
        repeat (20) step();
        chk("abort_no_valid", 32'(n_valid - v0), 0);

        // Reset together with start: no conversion begins.
        bin   = 16'd77;
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy0", 32'(busy), 0);
        step();
        chk("rst_start_busy1", 32'(busy), 0);
        v0 = n_valid;
        repeat (20) step();
        chk("rst_start_no_valid", 32'(n_valid - v0), 0);

        // Held start: back-to-back conversions every 18 cycles, output stable between.
        bin   = 16'd300;
        start = 1'b1;
        n     = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            e.bcd = 16'h0300;
            e.ovf = 1'b0;
            e.cyc = n + 17 + 18 * i;
            exp_q.push_back(e);
        end
        v0 = n_valid;
        for (int k = 0; k < 100 && (n_valid - v0) < 4; k++) begin
            step();
            if ((n_valid - v0) >= 1) chk("held_stable", 32'(bcd), 32'h0300);
        end
        start = 1'b0;
        drain(5);
        repeat (20) step();
        chk("held_valid_count", 32'(n_valid - v0), 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) between the system register output and the 4-digit 7-segment selector.
- Converts the low 16 bits of the register into 4 packed BCD digits, so the display shows decimal instead of hex.
- Values above 9999 saturate to 9999 and raise an overflow flag.
- bcd_o holds the last result, so the selector reads a stable value between conversions.

Parameters:
- BIN_W, 16, binary input width.
- DIGITS, 4, BCD digits presented on bcd_o.
- INT_DIGITS, 5, internal BCD digits; must satisfy 10^INT_DIGITS > 2^BIN_W.

Ports:
- clk_i  input  1  system clock (50 MHz).
- rst_i  input  1  synchronous, active-high reset.
- bin_i  input  BIN_W  binary value to convert; sampled only when a start is accepted.
- start_i  input  1  conversion request.
- bcd_o  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0], feeds selector reg_16_i.
- ovf_o  output  1  last result saturated (input > 10^DIGITS-1).
- busy_o  output  1  conversion in progress.
- valid_o  output  1  one-cycle pulse when bcd_o/ovf_o are updated.

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-high on rst_i. All state updates on the rising edge of clk_i.
- Reset values: bcd_o=0, ovf_o=0, busy_o=0, valid_o=0. FSM goes to IDLE, the shift counter clears, and the internal BCD/shift registers clear.
- FSM states and transitions:
  - IDLE: start_i=1 at edge N captures bin_i into the shift register, clears the INT_DIGITS scratch BCD register, loads counter=BIN_W, moves to SHIFT. busy_o=1 from N+1.
  - SHIFT: one iteration per edge. First, every scratch digit >=5 gets +3 (4-bit add, no carry out of the digit). Then {scratch, shift} shifts left by 1 and the counter decrements. After the edge where the counter reaches 0, move to DONE. SHIFT occupies edges N+1..N+BIN_W.
  - DONE (edge N+BIN_W+1):
    - If any scratch digit with index >= DIGITS is nonzero: bcd_o = all digits 9, ovf_o=1.
    - Else: bcd_o = scratch digits [DIGITS-1:0], ovf_o=0.
    - valid_o=1 for exactly this cycle, busy_o=0, return to IDLE.
- Latency: start accepted at N -> valid_o high and bcd_o new in the cycle after edge N+17 (BIN_W=16). Throughput is one conversion per 18 cycles.
- start_i while in SHIFT or DONE is ignored: no queuing, and bin_i changes have no effect. start_i held high restarts on the first IDLE cycle.
- bcd_o and ovf_o change only in DONE or on reset. A conversion aborted by reset never produces valid_o.
- Reset asserted in the same cycle as start_i: reset wins, and no conversion starts.
- bin_i=0 gives bcd_o=0, ovf_o=0. The boundary 9999 is not saturated; 10000 is.

Decomposition:
- Shared package bin2bcd_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - the BCD_NINE=4'h9 constant;
  - the DIGIT_W=4 constant;
  - a localparam for the counter width, clog2(BIN_W+1).
- One natural sub-module, bcd_add3: combinational 4-bit digit corrector (in>=5 ? in+3 : in), instantiated INT_DIGITS times by generate.

Test Plan:
- Reset, then start with bin_i=16'h04D2 (1234) at edge N -> valid_o pulse only at N+17, bcd_o=16'h1234, ovf_o=0; busy_o high N+1..N+16.
- bin_i=9999 -> bcd_o=16'h9999, ovf_o=0. bin_i=0 -> bcd_o=16'h0000, ovf_o=0.
- bin_i=10000 -> bcd_o=16'h9999, ovf_o=1. bin_i=65535 -> bcd_o=16'h9999, ovf_o=1. A following conversion of 42 -> bcd_o=16'h0042, ovf_o=0.
- Start converting 1234, then at N+5 change bin_i to 5678 and pulse start_i -> result 16'h1234, exactly one valid_o. A start at N+17 (DONE) is ignored; a start at N+18 converts 5678 -> 16'h5678 at N+35.
- Convert 1234 to completion, start converting 8765, assert rst_i at N+8 -> after that edge all outputs 0, FSM IDLE, no valid_o for 20 cycles. Reset together with start_i -> busy_o stays 0.
- start_i held high continuously with bin_i=300 -> valid_o pulses every 18 cycles, bcd_o=16'h0300 stable in between.
